// File: rtl/flag_unit.sv
// Architectural flags register with forwarded branch-condition evaluation
// over a valid/ready handshake, plus a small LIFO flag stack for save/restore.
module flag_unit #(
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flag_we,
  input  logic       zero_in,
  input  logic       carry_in,
  input  logic       overflow_in,
  input  logic       sign_in,
  input  logic       cond_valid,
  output logic       cond_ready,
  input  logic [3:0] cond_code,
  output logic       br_valid,
  input  logic       br_ready,
  output logic       br_taken,
  input  logic       push,
  input  logic       pop,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       stack_err,
  output logic [3:0] flags_out
);

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned CNT_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [FLAG_W-1:0] stack_q [STACK_DEPTH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              br_valid_q, br_valid_d;
  logic              br_taken_q, br_taken_d;

  logic              full_c, empty_c;
  logic              push_ok_c, pop_ok_c, err_set_c;
  logic              accept_c, eval_c;
  logic [IDX_W-1:0]  top_idx_c, wr_idx_c;
  logic              z_c, c_c, v_c, s_c;

  assign full_c    = (cnt_q == CNT_W'(STACK_DEPTH));
  assign empty_c   = (cnt_q == '0);
  assign top_idx_c = IDX_W'(cnt_q - CNT_W'(1));
  assign wr_idx_c  = IDX_W'(cnt_q);
  assign accept_c  = cond_valid & cond_ready;

  // Stack legality, next-flags selection and forwarded condition evaluation
  always_comb begin
    push_ok_c  = 1'b0;
    pop_ok_c   = 1'b0;
    err_set_c  = 1'b0;
    flags_d    = flags_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    eval_c     = 1'b0;
    br_valid_d = br_valid_q;
    br_taken_d = br_taken_q;

    if (push && pop) begin
      err_set_c = 1'b1;
    end else if (push) begin
      push_ok_c = ~full_c;
      err_set_c = full_c;
    end else if (pop) begin
      pop_ok_c  = ~empty_c;
      err_set_c = empty_c;
    end

    if (pop_ok_c) begin
      flags_d = stack_q[top_idx_c];
    end else if (flag_we) begin
      flags_d = {sign_in, overflow_in, carry_in, zero_in};
    end

    if (push_ok_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_ok_c) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    err_d = err_q | err_set_c;

    z_c = flags_d[0];
    c_c = flags_d[1];
    v_c = flags_d[2];
    s_c = flags_d[3];

    case (cond_code)
      4'h0:    eval_c = z_c;
      4'h1:    eval_c = ~z_c;
      4'h2:    eval_c = c_c;
      4'h3:    eval_c = ~c_c;
      4'h4:    eval_c = s_c;
      4'h5:    eval_c = ~s_c;
      4'h6:    eval_c = v_c;
      4'h7:    eval_c = ~v_c;
      4'h8:    eval_c = ~c_c & ~z_c;
      4'h9:    eval_c = c_c | z_c;
      4'hA:    eval_c = (s_c == v_c);
      4'hB:    eval_c = (s_c != v_c);
      4'hC:    eval_c = ~z_c & (s_c == v_c);
      4'hD:    eval_c = z_c | (s_c != v_c);
      4'hE:    eval_c = 1'b1;
      default: eval_c = 1'b0;
    endcase

    if (accept_c) begin
      br_valid_d = 1'b1;
      br_taken_d = eval_c;
    end else if (br_ready) begin
      br_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      br_valid_q <= 1'b0;
      br_taken_q <= 1'b0;
    end else begin
      flags_q    <= flags_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      br_valid_q <= br_valid_d;
      br_taken_q <= br_taken_d;
    end
  end

  // Stack contents need no reset; the count alone defines validity
  always_ff @(posedge clk) begin
    if (!rst && push_ok_c) begin
      stack_q[wr_idx_c] <= flags_d;
    end
  end

  assign cond_ready  = ~br_valid_q | br_ready;
  assign br_valid    = br_valid_q;
  assign br_taken    = br_taken_q;
  assign stack_full  = full_c;
  assign stack_empty = empty_c;
  assign stack_err   = err_q;
  assign flags_out   = flags_q;

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Consumer end of the ALU status interface: captures the zero/carry/overflow/sign flags the ALU produces into an architectural flags register.
- Evaluates branch condition codes against those flags and returns a registered taken/not-taken result over a valid/ready handshake.
- Provides a small LIFO flag stack (push/pop) for interrupt/call save-restore.
- Sits between the execute stage (ALU) and the fetch/branch logic.

Parameters:
STACK_DEPTH, 4, number of flag-stack entries (>=2)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
flag_we  input  1  write ALU flags into flags register this cycle
zero_in  input  1  ALU zero flag
carry_in  input  1  ALU carry flag (borrow after SUB)
overflow_in  input  1  ALU signed-overflow flag
sign_in  input  1  ALU sign flag
cond_valid  input  1  condition-evaluation request valid
cond_ready  output  1  unit can accept a request
cond_code  input  4  condition to evaluate
br_valid  output  1  result valid
br_ready  input  1  consumer accepts result
br_taken  output  1  condition true
push  input  1  save flags onto stack
pop  input  1  restore flags from stack
stack_full  output  1  STACK_DEPTH entries held
stack_empty  output  1  no entries held
stack_err  output  1  sticky error: overflow/underflow/illegal push+pop
flags_out  output  4  current flags {sign, overflow, carry, zero}

Behaviour:
- Reset (synchronous, active-high, wins over all inputs): flags_out=0, stack count=0, stack_empty=1, stack_full=0, stack_err=0, br_valid=0, br_taken=0. Reset mid-handshake drops any pending result.
- Next-flags priority, computed each cycle:
  - pop (legal): top of stack.
  - else flag_we: incoming ALU flags.
  - else: hold.
- Push:
  - Stores the next-flags value (forwarded if flag_we is high that cycle), so push with flag_we saves the new ALU flags.
  - Push when full: no change to stack; stack_err<=1.
- Pop:
  - Pop when empty: no change to stack or flags; flag_we still applies; stack_err<=1.
  - push and pop in the same cycle: neither acts; flag_we still applies; stack_err<=1.
- stack_err clears only on reset.
- stack_full/stack_empty are derived from the registered count; they update the cycle after a push or pop.
- Handshake:
  - cond_ready = ~br_valid | br_ready (combinational).
  - A request is accepted when cond_valid & cond_ready. The next cycle br_valid=1 and br_taken=eval(cond_code, next-flags of the accept cycle). Evaluation therefore sees a same-cycle flag_we or pop: 1-cycle latency with forwarding.
  - br_valid/br_taken hold stable while br_valid & ~br_ready.
  - br_ready with no new accept: br_valid<=0.
  - Accept with br_ready in the same cycle gives back-to-back results, one per cycle.
- Condition codes (Z=zero, C=carry, V=overflow, S=sign):
  - 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI S; 5 PL ~S; 6 VS V; 7 VC ~V.
  - 8 HI ~C&~Z (unsigned >, borrow semantics); 9 LS C|Z.
  - A GE S==V; B LT S!=V; C GT ~Z&(S==V); D LE Z|(S!=V).
  - E AL 1; F NV 0.

Test Plan:
- Reset then flag_we with Z=1,C=0,V=0,S=0 -> flags_out=4'b0001 next cycle; cond_code=0 accepted -> br_valid=1, br_taken=1 one cycle later.
- Forwarding: same cycle flag_we {S=1,V=0,C=0,Z=0} and cond_code=B (LT) while old flags are 0 -> br_taken=1. Same setup with cond_code=A (GE) -> br_taken=0.
- Backpressure: accept HI with flags C=0,Z=0, hold br_ready=0 for 3 cycles -> br_valid/br_taken=1 stable, cond_ready=0. Then br_ready=1 with new request NV in the same cycle -> next cycle br_valid=1, br_taken=0.
- Stack: push flags 4'b0001, 4'b0010, 4'b0100, 4'b1000 -> stack_full=1. Fifth push -> stack_err=1 and depth stays 4. Four pops -> flags_out 4'b1000, 4'b0100, 4'b0010, 4'b0001, stack_empty=1. Fifth pop -> flags_out unchanged.
- Pop and flag_we in the same cycle -> flags_out = stacked value. push+pop together -> count unchanged, stack_err=1.
- Exhaustive: sweep all 16 cond_codes across all 16 flag combinations -> br_taken matches the table; rst asserted with br_valid=1 -> br_valid=0, flags_out=0, stack_err=0 next cycle.
